// File: rtl/seg_decoder.sv
// seg_decoder: snoops a time-multiplexed 7-segment display bus, waits for each
// digit to be stable, decodes the segment pattern back into a hex nibble and
// assembles a DIGITS-wide frame delivered on a valid/ready port.
//
// Build option: define SEG_DECODER_DP_EN to capture segs[0] (decimal point)
// into out_dp; otherwise segs[0] is ignored everywhere and out_dp stays 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   segs[7:0]  segment lines {a,b,c,d,e,f,g,dp}, active-high
//   an         one-hot digit enables, bit i = digit i
//   out_valid  frame available (held until accepted)
//   out_ready  consumer accepts frame
//   out_value  decoded frame, nibble i = digit i
//   out_dp     decimal point per digit
//   out_bad    digit i had an undecodable pattern
//   overflow   sticky: a completed frame was dropped
module seg_decoder #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          segs,
    input  logic [DIGITS-1:0]   an,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_value,
    output logic [DIGITS-1:0]   out_dp,
    output logic [DIGITS-1:0]   out_bad,
    output logic                overflow
);
    localparam int unsigned FW = 4 * DIGITS;
    localparam int unsigned CW = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

`ifdef SEG_DECODER_DP_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
`else
    localparam logic [7:0] SEG_MASK = 8'hFE;
`endif

    logic [1:0]        state, state_next;
    logic [CW-1:0]     count, count_next;
    logic [DIGITS-1:0] sample_an;
    logic [7:0]        sample_segs;
    logic [7:0]        segs_m;
    logic              an_onehot_c, match_c, capture_c, frame_done_c;
    logic [3:0]        nib_c;
    logic              bad_c;
    logic [FW-1:0]     slot_value, slot_value_next;
    logic [DIGITS-1:0] slot_dp, slot_dp_next;
    logic [DIGITS-1:0] slot_bad, slot_bad_next;
    logic [DIGITS-1:0] seen, seen_next;

    // dp bit is masked out of both the sample and the comparison when unused
    assign segs_m      = segs & SEG_MASK;
    assign an_onehot_c = (an != '0) && ((an & (an - DIGITS'(1))) == '0);
    assign match_c     = ({an, segs_m} == {sample_an, sample_segs});

    // Segment pattern {a..g} to hex nibble
    always_comb begin
        nib_c = 4'h0;
        bad_c = 1'b0;
        case (segs[7:1])
            7'b1111110: nib_c = 4'h0;
            7'b0110000: nib_c = 4'h1;
            7'b1101101: nib_c = 4'h2;
            7'b1111001: nib_c = 4'h3;
            7'b0110011: nib_c = 4'h4;
            7'b1011011: nib_c = 4'h5;
            7'b1011111: nib_c = 4'h6;
            7'b1110000: nib_c = 4'h7;
            7'b1111111: nib_c = 4'h8;
            7'b1111011: nib_c = 4'h9;
            7'b1110111: nib_c = 4'hA;
            7'b0011111: nib_c = 4'hB;
            7'b1001110: nib_c = 4'hC;
            7'b0111101: nib_c = 4'hD;
            7'b1001111: nib_c = 4'hE;
            7'b1000111: nib_c = 4'hF;
            default:    bad_c = 1'b1;
        endcase
    end

    // Settle FSM: capture once inputs have matched the sample for STABLE cycles
    always_comb begin
        state_next = state;
        count_next = count;
        capture_c  = 1'b0;
        if (!an_onehot_c) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_SETTLE;
                    count_next = '0;
                end
                ST_SETTLE: begin
                    if (!match_c) begin
                        count_next = '0;
                    end else if (count == CW'(STABLE - 1)) begin
                        capture_c  = 1'b1;
                        state_next = ST_CAPTURED;
                        count_next = '0;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
                ST_CAPTURED: begin
                    if (!match_c) begin
                        state_next = ST_SETTLE;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Slot update for the digit being captured this cycle
    always_comb begin
        slot_value_next = slot_value;
        slot_dp_next    = slot_dp;
        slot_bad_next   = slot_bad;
        seen_next       = seen;
        if (capture_c) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an[i]) begin
                    slot_value_next[4*i +: 4] = nib_c;
                    slot_dp_next[i]           = segs_m[0];
                    slot_bad_next[i]          = bad_c;
                    seen_next[i]              = 1'b1;
                end
            end
        end
    end

    assign frame_done_c = capture_c && (seen_next == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            sample_an   <= '0;
            sample_segs <= '0;
            slot_value  <= '0;
            slot_dp     <= '0;
            slot_bad    <= '0;
            seen        <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            sample_an   <= an;
            sample_segs <= segs_m;
            slot_value  <= slot_value_next;
            slot_dp     <= slot_dp_next;
            slot_bad    <= slot_bad_next;
            seen        <= frame_done_c ? '0 : seen_next;
        end
    end

    // Output port: a completed frame loads unless an unaccepted frame is held
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_dp    <= '0;
            out_bad   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (frame_done_c && !(out_valid && !out_ready)) begin
                out_valid <= 1'b1;
                out_value <= slot_value_next;
                out_dp    <= slot_dp_next;
                out_bad   <= slot_bad_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (frame_done_c && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_decoder.sv
// Testbench for seg_decoder (DIGITS=8, STABLE=4): directed scenarios plus a
// randomized run against a run-length based reference model.
module tb_seg_decoder;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned STABLE = 4;

`ifdef SEG_DECODER_DP_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
`else
    localparam logic [7:0] SEG_MASK = 8'hFE;
`endif

    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  segs;
    logic [7:0]  an;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [7:0]  out_dp;
    logic [7:0]  out_bad;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_prev;
    int          m_rl;
    logic [31:0] m_slot_val;
    logic [7:0]  m_slot_dp, m_slot_bad, m_seen;
    logic        m_valid, m_ovf;
    logic [31:0] m_value;
    logic [7:0]  m_dp, m_bad;

    seg_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .segs(segs), .an(an),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_dp(out_dp), .out_bad(out_bad), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
        return {PAT[n], dp};
    endfunction

    // Drive one cycle of inputs and advance the model with the same inputs
    task automatic step(input logic [7:0] a, input logic [7:0] s, input logic r);
        logic [15:0] cur;
        logic        cap, done, bd;
        logic [3:0]  nib;
        int          idx;
        an = a; segs = s; out_ready = r;
        @(posedge clk);
        if (rst) begin
            m_prev = '0; m_rl = 0; m_slot_val = '0; m_slot_dp = '0; m_slot_bad = '0;
            m_seen = '0; m_valid = 1'b0; m_ovf = 1'b0; m_value = '0; m_dp = '0; m_bad = '0;
        end else begin
            cur = {a, s & SEG_MASK};
            m_rl = (cur == m_prev) ? m_rl + 1 : 1;
            m_prev = cur;
            cap = ($countones(a) == 1) && (m_rl == STABLE + 1);
            done = 1'b0;
            if (cap) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (a[i]) idx = i;
                nib = 4'h0; bd = 1'b1;
                for (int k = 0; k < 16; k++) if (PAT[k] == s[7:1]) begin nib = 4'(k); bd = 1'b0; end
                m_slot_val[4*idx +: 4] = nib;
                m_slot_dp[idx] = cur[0];
                m_slot_bad[idx] = bd;
                m_seen[idx] = 1'b1;
                done = (m_seen == 8'hFF);
            end
            if (done) begin
                m_seen = '0;
                if (m_valid && !r) m_ovf = 1'b1;
                else begin
                    m_valid = 1'b1; m_value = m_slot_val; m_dp = m_slot_dp; m_bad = m_slot_bad;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [7:0] s, input int cycles, input logic r);
        for (int c = 0; c < cycles; c++) step(8'(1 << idx), s, r);
    endtask

    task automatic drive_frame(input logic [31:0] val, input logic [7:0] dps);
        for (int i = 0; i < 8; i++) drive_digit(i, seg_of(val[4*i +: 4], dps[i]), 6, 1'b0);
    endtask

    task automatic accept();
        step(an, segs, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00, 8'h00, 1'b0);
        step(8'h00, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", out_valid); end
        checks++; if (out_value !== 32'h0) begin errors++; $display("FAIL reset_value got %h want 0", out_value); end
        checks++; if (out_dp !== 8'h0) begin errors++; $display("FAIL reset_dp got %h want 0", out_dp); end
        checks++; if (out_bad !== 8'h0) begin errors++; $display("FAIL reset_bad got %h want 0", out_bad); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %h want 0", overflow); end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 8; i++) drive_digit(i, seg_of(4'(8 - i), 1'b0), 6, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %h want 1", out_valid); end
        checks++; if (out_value !== 32'h12345678) begin errors++; $display("FAIL frame_value got %h want 12345678", out_value); end
        checks++; if (out_bad !== 8'h00) begin errors++; $display("FAIL frame_bad got %h want 00", out_bad); end
        accept();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_accept got %h want 0", out_valid); end
    endtask

    task automatic test_bad_digit();
        logic [31:0] val, expv;
        val = $urandom;
        expv = val; expv[15:12] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive_digit(i, 8'h6E, 10, 1'b0);
            else drive_digit(i, seg_of(val[4*i +: 4], 1'b0), 6, 1'b0);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_valid got %h want 1", out_valid); end
        checks++; if (out_bad !== 8'h08) begin errors++; $display("FAIL bad_mask got %h want 08", out_bad); end
        checks++; if (out_value !== expv) begin errors++; $display("FAIL bad_value got %h want %h", out_value, expv); end
        accept();
    endtask

    // Digit 2 last so a wrongly captured glitch would itself complete the frame
    task automatic test_glitch();
        logic [31:0] val, expv;
        for (int g = 3; g <= 4; g++) begin
            val = $urandom;
            expv = val; expv[11:8] = 4'h0;
            for (int i = 0; i < 8; i++)
                if (i != 2) drive_digit(i, seg_of(val[4*i +: 4], 1'b0), 6, 1'b0);
            drive_digit(2, seg_of(4'h5, 1'b0), g, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL glitch%0d_early got %h want 0", g, out_valid); end
            drive_digit(2, seg_of(4'h0, 1'b0), 5, 1'b0);
            checks++; if (out_value !== expv || out_bad !== 8'h00 || out_valid !== 1'b1) begin
                errors++; $display("FAIL glitch%0d_frame got v=%h b=%h val=%h want 1 00 %h", g, out_valid, out_bad, out_value, expv);
            end
            accept();
        end
    endtask

    task automatic test_overflow();
        logic [31:0] a_val, b_val;
        a_val = $urandom;
        b_val = ~a_val;
        drive_frame(a_val, 8'h00);
        checks++; if (out_valid !== 1'b1 || out_value !== a_val) begin
            errors++; $display("FAIL ovf_first got v=%h val=%h want 1 %h", out_valid, out_value, a_val);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %h want 0", overflow); end
        drive_frame(b_val, 8'h00);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %h want 1", overflow); end
        checks++; if (out_valid !== 1'b1 || out_value !== a_val) begin
            errors++; $display("FAIL ovf_hold got v=%h val=%h want 1 %h", out_valid, out_value, a_val);
        end
        accept();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %h want 0", out_valid); end
    endtask

    task automatic test_not_onehot();
        logic [31:0] val;
        val = 32'h9876_5432;
        for (int i = 0; i < 4; i++) drive_digit(i, seg_of(val[4*i +: 4], 1'b0), 6, 1'b0);
        for (int c = 0; c < 20; c++) step(8'h03, seg_of(4'hE, 1'b0), 1'b0);
        for (int c = 0; c < 3; c++) step(8'h00, seg_of(4'hE, 1'b0), 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL onehot_novalid got %h want 0", out_valid); end
        for (int i = 4; i < 8; i++) drive_digit(i, seg_of(val[4*i +: 4], 1'b0), 6, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_value !== val) begin
            errors++; $display("FAIL onehot_frame got v=%h val=%h want 1 %h", out_valid, out_value, val);
        end
        accept();
    endtask

    task automatic test_mid_reset();
        logic [31:0] x_val, y_val, expv;
        x_val = $urandom; y_val = $urandom;
        for (int i = 0; i < 4; i++) drive_digit(i, seg_of(x_val[4*i +: 4], 1'b0), 6, 1'b0);
        do_reset();
        for (int i = 4; i < 8; i++) drive_digit(i, seg_of(y_val[4*i +: 4], 1'b0), 6, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial got %h want 0", out_valid); end
        for (int i = 0; i < 4; i++) drive_digit(i, seg_of(y_val[4*i +: 4], 1'b0), 6, 1'b0);
        expv = y_val;
        checks++; if (out_valid !== 1'b1 || out_value !== expv) begin
            errors++; $display("FAIL rst_frame got v=%h val=%h want 1 %h", out_valid, out_value, expv);
        end
        accept();
    endtask

    task automatic test_dp();
        logic [31:0] val;
        logic [7:0]  exp_dp;
`ifdef SEG_DECODER_DP_EN
        exp_dp = 8'h81;
`else
        exp_dp = 8'h00;
`endif
        val = $urandom;
        drive_frame(val, 8'h81);
        checks++; if (out_dp !== exp_dp) begin errors++; $display("FAIL dp_mask got %h want %h", out_dp, exp_dp); end
        checks++; if (out_valid !== 1'b1 || out_value !== val) begin
            errors++; $display("FAIL dp_value got v=%h val=%h want 1 %h", out_valid, out_value, val);
        end
        accept();
    endtask

    task automatic test_random();
        logic [7:0] a, s;
        int sel, len;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 85) a = 8'(1 << $urandom_range(0, 7));
            else if (sel < 92) a = 8'h00;
            else a = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) s = seg_of(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else s = 8'($urandom);
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                step(a, s, 1'($urandom_range(0, 1)));
                checks++;
                if (out_valid !== m_valid || out_value !== m_value || out_dp !== m_dp ||
                    out_bad !== m_bad || overflow !== m_ovf) begin
                    errors++;
                    $display("FAIL random got v=%h val=%h dp=%h bad=%h ovf=%h want v=%h val=%h dp=%h bad=%h ovf=%h",
                             out_valid, out_value, out_dp, out_bad, overflow,
                             m_valid, m_value, m_dp, m_bad, m_ovf);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; an = '0; segs = '0; out_ready = 1'b0;
        test_reset();
        test_frame();
        test_bad_digit();
        test_glitch();
        test_overflow();
        test_not_onehot();
        test_mid_reset();
        test_dp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
